ibex_rf_wport_arbiter: RTL
==========================

Name: ibex_rf_wport_arbiter

Overview:
Arbitrates the single register-file write port between in-order ID/EX results and out-of-band LSU load responses. Tracks outstanding load destinations in a 32-entry pending scoreboard, which drives RAW hazard flags for operand reads and WAW stalls for EX writes. Parks load data in a small in-order FIFO when EX is granted the port after starving, so load responses are never back-pressured. It sits between the ID/EX and writeback logic and the register file.

Parameters:
FifoDepth, 2, load-data skid FIFO entries (legal 1..4)
StarveLimit, 4, consecutive contention-stalled EX cycles before EX gets priority (legal 1..15)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
ex_valid_i  in  1  EX result wants to write
ex_ready_o  out  1  EX result accepted this cycle
ex_waddr_i  in  5  EX destination register
ex_wdata_i  in  32  EX write data
ld_issue_i  in  1  load accepted by LSU; mark destination pending
ld_issue_ready_o  out  1  issue allowed; low if destination already pending
ld_issue_waddr_i  in  5  load destination register
lsu_resp_valid_i  in  1  load response; cannot be stalled
lsu_resp_err_i  in  1  load response is a bus error
lsu_resp_waddr_i  in  5  response destination
lsu_resp_wdata_i  in  32  load data
raddr_a_i, raddr_b_i  in  5 each  operand read addresses
hazard_a_o, hazard_b_o  out  1 each  operand register has a pending load
rf_we_o  out  1  RF write enable
rf_waddr_o  out  5  RF write address
rf_wdata_o  out  32  RF write data

Behaviour:
- State: pending[31:1], FIFO (addr+data, count 0..FifoDepth), starve_cnt. All cleared while rst_ni=0 at clock edge.
- All outputs are combinational from state and inputs; zero latency. While rst_ni=0, every output is forced to 0.
- LSU source (S): FIFO head if count>0, else live response if lsu_resp_valid_i & ~lsu_resp_err_i & waddr!=0.
- Error or x0 responses: never written, never pushed. An error response clears pending[waddr] in the same cycle.
- EX blocked (WAW) when ex_waddr_i!=0 & pending[ex_waddr_i]. Blocked EX gets ex_ready_o=0 and does not count as starvation.
- EX to x0: ex_ready_o=1 at once, rf_we_o=0, no port use, starve_cnt reset.
- Grant EX (eligible: valid, !blocked, waddr!=0):
  - EX wins if there is no S, or if starve_cnt==StarveLimit and count<FifoDepth.
  - Otherwise S wins and ex_ready_o=0.
- When EX wins with S present:
  - A live response is pushed.
  - The FIFO head stays in place.
- When S (FIFO head) wins:
  - The head is popped.
  - A valid live response is pushed in the same cycle, so order is preserved.
- A live response that arrives while count>0 is always pushed.
- A push on a full FIFO without a pop cannot occur by construction. It is asserted.
- rf_we_o=1 only on a granted write. rf_waddr_o/rf_wdata_o come from the winner. When S wins, pending[addr] is cleared at the next edge.
- starve_cnt:
  - Increments (saturating at StarveLimit) when EX is eligible and loses.
  - Resets to 0 when EX is granted or ex_valid_i=0.
  - Holds when EX is blocked.
- ld_issue_ready_o = ~pending[ld_issue_waddr_i] | ld_issue_waddr_i==0.
- A pending bit is set on ld_issue_i & ld_issue_ready_o & waddr!=0.
- Set and clear of different registers in the same cycle both take effect.
- hazard_x_o = raddr!=0 & pending[raddr]. It stays high while the data sits in the FIFO and drops the cycle after the RF write.
- Assertions:
  - A non-error response to waddr!=0 hits a pending register.
  - rf_we_o implies rf_waddr_o!=0.
  - count<=FifoDepth.

Test Plan:
- Issue load x5, respond 0xDEAD_BEEF in cycle 3 with no EX traffic -> rf_we_o=1 in cycle 3, waddr 5, data 0xDEADBEEF; hazard_a_o for raddr 5 is high cycles 1–3 and low in cycle 4.
- EX write x7 while load x5 responds in the same cycle -> LSU wins, ex_ready_o=0; EX writes x7 next cycle; starve_cnt reaches 1 then resets.
- StarveLimit=4, LSU responds on 5 consecutive cycles while EX is valid -> EX granted in cycle 5; that response is pushed (count=1) and written in cycle 6.
- FifoDepth=2, FIFO full and starve_cnt saturated -> LSU keeps winning until count<2; no overflow assertion fires.
- Load x9 pending, EX writes x9 -> ex_ready_o=0 with starve_cnt unchanged; an error response for x9 clears pending with no write; EX write is accepted next cycle.
- Apply rst_ni=0 with count=2 and pending bits set -> all outputs 0; after release, FIFO is empty, pending is 0, and hazards are 0.

Source files
------------

// File: rtl/ibex_rf_wport_arbiter_if.sv
// rtl/ibex_rf_wport_arbiter_if.sv - EX, LSU, operand-read and RF write-port signals of the arbiter
interface ibex_rf_wport_arbiter_if;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ld_issue_i;
    logic        ld_issue_ready_o;
    logic [4:0]  ld_issue_waddr_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [4:0]  lsu_resp_waddr_i;
    logic [31:0] lsu_resp_wdata_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic        hazard_a_o;
    logic        hazard_b_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  ld_issue_i, ld_issue_waddr_i,
        input  lsu_resp_valid_i, lsu_resp_err_i, lsu_resp_waddr_i, lsu_resp_wdata_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o, ld_issue_ready_o, hazard_a_o, hazard_b_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output ld_issue_i, ld_issue_waddr_i,
        output lsu_resp_valid_i, lsu_resp_err_i, lsu_resp_waddr_i, lsu_resp_wdata_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o, ld_issue_ready_o, hazard_a_o, hazard_b_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/ibex_rf_wport_arbiter.sv
// rtl/ibex_rf_wport_arbiter.sv - RF write-port arbiter between EX results and unstallable load responses
module ibex_rf_wport_arbiter #(
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 4
) (
    input logic clk_i,
    input logic rst_ni,
    ibex_rf_wport_arbiter_if.slave bus
);
    localparam int unsigned MaxDepth  = 4;
    localparam logic [2:0]  DepthC    = 3'(FifoDepth);
    localparam logic [3:0]  StarveMax = 4'(StarveLimit);

    logic [31:0] pending_q, pending_d, pend_set, pend_clr;
    logic [4:0]  fifo_addr_q [MaxDepth];
    logic [31:0] fifo_data_q [MaxDepth];
    logic [2:0]  count_q;
    logic [3:0]  starve_q, starve_d;

    logic        live_ok, err_resp, fifo_nonempty, s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        ex_zero, ex_blocked, ex_elig, ex_win, s_win;
    logic        pop, push, ld_ready;
    logic [1:0]  wr_idx;

    assign fifo_nonempty = (count_q != 3'd0);
    assign live_ok  = bus.lsu_resp_valid_i & ~bus.lsu_resp_err_i & (bus.lsu_resp_waddr_i != 5'd0);
    assign err_resp = bus.lsu_resp_valid_i &  bus.lsu_resp_err_i & (bus.lsu_resp_waddr_i != 5'd0);

    // Queued data always drains before a live response so writes stay in load order.
    assign s_valid = fifo_nonempty | live_ok;
    assign s_addr  = fifo_nonempty ? fifo_addr_q[0] : bus.lsu_resp_waddr_i;
    assign s_data  = fifo_nonempty ? fifo_data_q[0] : bus.lsu_resp_wdata_i;

    assign ex_zero    = bus.ex_valid_i & (bus.ex_waddr_i == 5'd0);
    assign ex_blocked = bus.ex_valid_i & (bus.ex_waddr_i != 5'd0) & pending_q[bus.ex_waddr_i];
    assign ex_elig    = bus.ex_valid_i & (bus.ex_waddr_i != 5'd0) & ~pending_q[bus.ex_waddr_i];
    assign ex_win     = ex_elig & (~s_valid | ((starve_q == StarveMax) & (count_q < DepthC)));
    assign s_win      = s_valid & ~ex_win;

    // A live response not written directly this cycle is queued behind the head.
    assign pop    = s_win & fifo_nonempty;
    assign push   = live_ok & (fifo_nonempty | ex_win);
    assign wr_idx = count_q[1:0] - {1'b0, pop};

    assign ld_ready = ~pending_q[bus.ld_issue_waddr_i] | (bus.ld_issue_waddr_i == 5'd0);

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        starve_d = starve_q;
        if (s_win) pend_clr[s_addr] = 1'b1;
        if (err_resp) pend_clr[bus.lsu_resp_waddr_i] = 1'b1;
        if (bus.ld_issue_i & ld_ready & (bus.ld_issue_waddr_i != 5'd0)) begin
            pend_set[bus.ld_issue_waddr_i] = 1'b1;
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
        if (ex_elig & ~ex_win) begin
            if (starve_q != StarveMax) starve_d = starve_q + 4'd1;
        end else if (!ex_blocked) begin
            starve_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            for (int i = 0; i < MaxDepth; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
            count_q   <= count_q + {2'b0, push} - {2'b0, pop};
            if (pop) begin
                for (int i = 0; i < MaxDepth - 1; i++) begin
                    fifo_addr_q[i] <= fifo_addr_q[i+1];
                    fifo_data_q[i] <= fifo_data_q[i+1];
                end
            end
            if (push) begin
                fifo_addr_q[wr_idx] <= bus.lsu_resp_waddr_i;
                fifo_data_q[wr_idx] <= bus.lsu_resp_wdata_i;
            end
        end
    end

    assign bus.ex_ready_o       = rst_ni & (ex_zero | ex_win);
    assign bus.ld_issue_ready_o = rst_ni & ld_ready;
    assign bus.hazard_a_o = rst_ni & (bus.raddr_a_i != 5'd0) & pending_q[bus.raddr_a_i];
    assign bus.hazard_b_o = rst_ni & (bus.raddr_b_i != 5'd0) & pending_q[bus.raddr_b_i];
    assign bus.rf_we_o    = rst_ni & (ex_win | s_win);
    assign bus.rf_waddr_o = {5{rst_ni}}  & (ex_win ? bus.ex_waddr_i : s_addr);
    assign bus.rf_wdata_o = {32{rst_ni}} & (ex_win ? bus.ex_wdata_i : s_data);

    a_resp_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        live_ok |-> pending_q[bus.lsu_resp_waddr_i]);
    a_we_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.rf_we_o |-> (bus.rf_waddr_o != 5'd0));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthC);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push & ~pop & (count_q == DepthC)));
endmodule
